// File: rtl/d_pkg.sv
// Shared decode definitions for the d1/d2 stages: format codes, RISC-V opcodes, buffer entry, decode helper.
// Build option D1_AMO_EN enables decoding of the AMO opcode into FMT_AMO with three micro-ops.
package d_pkg;

    localparam int D_XLEN = 32;

    localparam logic [4:0] FMT_R     = 5'd0;
    localparam logic [4:0] FMT_I     = 5'd1;
    localparam logic [4:0] FMT_LD    = 5'd2;
    localparam logic [4:0] FMT_S     = 5'd3;
    localparam logic [4:0] FMT_B     = 5'd4;
    localparam logic [4:0] FMT_U     = 5'd5;
    localparam logic [4:0] FMT_J     = 5'd6;
    localparam logic [4:0] FMT_JR    = 5'd7;
    localparam logic [4:0] FMT_SYS   = 5'd8;
    localparam logic [4:0] FMT_FENCE = 5'd9;
    localparam logic [4:0] FMT_AMO   = 5'd10;
    localparam logic [4:0] FMT_ILL   = 5'd31;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;

    typedef struct packed {
        logic [D_XLEN-1:0] pc;
        logic [D_XLEN-1:0] instr;
        logic [4:0]        fmt;
        logic [1:0]        cnt;
        logic              exc;
    } buf_entry_t;

    function automatic buf_entry_t decode_entry(input logic [D_XLEN-1:0] pc,
                                                input logic [D_XLEN-1:0] instr,
                                                input logic              fexc);
        buf_entry_t e;
        logic       ill;
        e.pc    = pc;
        e.instr = instr;
        e.fmt   = FMT_ILL;
        e.cnt   = 2'd0;
        ill     = 1'b0;
        if (instr[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (instr[6:0])
                OPC_OP:       e.fmt = FMT_R;
                OPC_OP_IMM:   e.fmt = FMT_I;
                OPC_LOAD:     e.fmt = FMT_LD;
                OPC_STORE:    begin e.fmt = FMT_S;  e.cnt = 2'd1; end
                OPC_BRANCH:   e.fmt = FMT_B;
                OPC_LUI,
                OPC_AUIPC:    e.fmt = FMT_U;
                OPC_JAL:      begin e.fmt = FMT_J;  e.cnt = 2'd1; end
                OPC_JALR:     begin e.fmt = FMT_JR; e.cnt = 2'd1; end
                OPC_SYSTEM:   e.fmt = FMT_SYS;
                OPC_MISC_MEM: e.fmt = FMT_FENCE;
`ifdef D1_AMO_EN
                OPC_AMO:      begin e.fmt = FMT_AMO; e.cnt = 2'd2; end
`endif
                default:      ill = 1'b1;
            endcase
        end
        if (ill) e.fmt = FMT_ILL;
        // Faulting instructions travel as a single uop carrying the exception.
        e.exc = ill | fexc;
        if (e.exc) e.cnt = 2'd0;
        return e;
    endfunction

endpackage

// File: rtl/d1_skid_buf.sv
// Two-entry FIFO holding decoded instructions between fetch and the d1 issue register.
module d1_skid_buf
    import d_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  buf_entry_t din,
    output buf_entry_t dout,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    buf_entry_t mem [2];
    logic       wr_ptr, rd_ptr;
    logic       push_ok, pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Storage needs no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/d1_uop_issue.sv
// First decode stage: decodes at enqueue, buffers two entries, and issues one uop per cycle to d2.
// AMO support is selected at build time by D1_AMO_EN (see d_pkg::decode_entry).
module d1_uop_issue
    import d_pkg::*;
#(
    parameter int XLEN = D_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            f_valid,
    output logic            f_ready,
    input  logic [XLEN-1:0] f_pc,
    input  logic [XLEN-1:0] f_instr,
    input  logic            f_exception,
    output logic            valid_out,
    input  logic            stall_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instruction_out,
    output logic [4:0]      opcode_format,
    output logic [1:0]      uop_count,
    output logic [1:0]      uop_idx,
    output logic            exception_out
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t     state;
    buf_entry_t enq, head;
    logic [1:0] buf_count;
    logic       buf_full, buf_empty;
    logic       push, pop, last_uop;

    assign enq      = decode_entry(f_pc, f_instr, f_exception);
    assign f_ready  = (buf_count < 2'd2);
    assign push     = f_valid & ~buf_full & ~flush;
    assign last_uop = (uop_idx == uop_count);
    // Load a new head when idle, or when the final uop of the current one is consumed.
    assign pop      = ~flush & ~buf_empty &
                      ((state == IDLE) | (~stall_in & last_uop));

    d1_skid_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (enq),
        .dout  (head),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            valid_out       <= 1'b0;
            pc_out          <= '0;
            instruction_out <= '0;
            opcode_format   <= '0;
            uop_count       <= '0;
            uop_idx         <= '0;
            exception_out   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            uop_idx   <= '0;
        end else if (pop) begin
            state           <= ISSUE;
            valid_out       <= 1'b1;
            pc_out          <= head.pc;
            instruction_out <= head.instr;
            opcode_format   <= head.fmt;
            uop_count       <= head.cnt;
            uop_idx         <= '0;
            exception_out   <= head.exc;
        end else if (state == ISSUE && !stall_in) begin
            if (!last_uop) begin
                uop_idx <= uop_idx + 2'd1;
            end else begin
                state     <= IDLE;
                valid_out <= 1'b0;
                uop_idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_d1_uop_issue.sv
// Self-checking bench for d1_uop_issue: decode table, hand-written corner sequences, random vs. uop-stream model.
module tb_d1_uop_issue;
    import d_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, f_valid, f_exception, stall_in;
    logic [31:0] f_pc, f_instr;
    logic        f_ready, valid_out, exception_out;
    logic [31:0] pc_out, instruction_out;
    logic [4:0]  opcode_format;
    logic [1:0]  uop_count, uop_idx;

    d1_uop_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .f_valid(f_valid), .f_ready(f_ready),
        .f_pc(f_pc), .f_instr(f_instr), .f_exception(f_exception),
        .valid_out(valid_out), .stall_in(stall_in), .pc_out(pc_out),
        .instruction_out(instruction_out), .opcode_format(opcode_format),
        .uop_count(uop_count), .uop_idx(uop_idx), .exception_out(exception_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        fexc;
        logic [4:0]  fmt;
        logic [1:0]  cnt;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  fmt;
        logic [1:0]  cnt;
        logic [1:0]  idx;
        logic        exc;
    } uop_t;

    vec_t vecs[$];
    uop_t q[$];

    function automatic vec_t mk(logic [31:0] i, logic fe, logic [4:0] f, logic [1:0] n, logic e);
        vec_t v;
        v.instr = i; v.fexc = fe; v.fmt = f; v.cnt = n; v.exc = e;
        return v;
    endfunction

    // Reference: format from the opcode, uop count derived from the format.
    function automatic void ref_dec(input logic [31:0] i, input logic fe,
                                    output logic [4:0] f, output logic [1:0] n, output logic e);
        logic [6:0] op;
        op = i[6:0];
        f  = FMT_ILL;
        if (i[1:0] == 2'b11) begin
            case (op)
                7'h33: f = FMT_R;
                7'h13: f = FMT_I;
                7'h03: f = FMT_LD;
                7'h23: f = FMT_S;
                7'h63: f = FMT_B;
                7'h37, 7'h17: f = FMT_U;
                7'h6F: f = FMT_J;
                7'h67: f = FMT_JR;
                7'h73: f = FMT_SYS;
                7'h0F: f = FMT_FENCE;
`ifdef D1_AMO_EN
                7'h2F: f = FMT_AMO;
`endif
                default: f = FMT_ILL;
            endcase
        end
        e = (f == FMT_ILL) || fe;
        if (e)                                           n = 2'd0;
        else if (f == FMT_S || f == FMT_J || f == FMT_JR) n = 2'd1;
        else if (f == FMT_AMO)                           n = 2'd2;
        else                                             n = 2'd0;
    endfunction

    task automatic consume_check();
        uop_t u;
        if (valid_out && !stall_in) begin
            if (q.size() == 0) begin
                chk("rnd_spurious_uop", 64'(valid_out), 64'd0);
            end else begin
                u = q.pop_front();
                chk("rnd_pc_instr", {pc_out, instruction_out}, {u.pc, u.instr});
                chk("rnd_side", {54'd0, opcode_format, uop_count, uop_idx, exception_out},
                    {54'd0, u.fmt, u.cnt, u.idx, u.exc});
            end
        end
    endtask

    localparam logic [31:0] ADD  = 32'h00B50533;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] LUI  = 32'h000010B7;
    localparam logic [31:0] SW   = 32'h00A12023;
    localparam logic [31:0] JAL  = 32'h008000EF;

    initial begin
        rst = 1'b1; flush = 1'b0; f_valid = 1'b0; f_exception = 1'b0; stall_in = 1'b0;
        f_pc = '0; f_instr = '0;

        vecs.push_back(mk(ADD,          1'b0, FMT_R,     2'd0, 1'b0));
        vecs.push_back(mk(ADDI,         1'b0, FMT_I,     2'd0, 1'b0));
        vecs.push_back(mk(32'h0000A103, 1'b0, FMT_LD,    2'd0, 1'b0));
        vecs.push_back(mk(SW,           1'b0, FMT_S,     2'd1, 1'b0));
        vecs.push_back(mk(32'h00000063, 1'b0, FMT_B,     2'd0, 1'b0));
        vecs.push_back(mk(LUI,          1'b0, FMT_U,     2'd0, 1'b0));
        vecs.push_back(mk(32'h00000097, 1'b0, FMT_U,     2'd0, 1'b0));
        vecs.push_back(mk(JAL,          1'b0, FMT_J,     2'd1, 1'b0));
        vecs.push_back(mk(32'h000080E7, 1'b0, FMT_JR,    2'd1, 1'b0));
        vecs.push_back(mk(32'h00000073, 1'b0, FMT_SYS,   2'd0, 1'b0));
        vecs.push_back(mk(32'h0000000F, 1'b0, FMT_FENCE, 2'd0, 1'b0));
        vecs.push_back(mk(32'hFFFFFFFF, 1'b0, FMT_ILL,   2'd0, 1'b1));
        vecs.push_back(mk(32'h00000000, 1'b0, FMT_ILL,   2'd0, 1'b1));
        vecs.push_back(mk(SW,           1'b1, FMT_S,     2'd0, 1'b1));
`ifdef D1_AMO_EN
        vecs.push_back(mk(32'h00B5202F, 1'b0, FMT_AMO,   2'd2, 1'b0));
`else
        vecs.push_back(mk(32'h00B5202F, 1'b0, FMT_ILL,   2'd0, 1'b1));
`endif

        // Reset
        step(); step();
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_uop_count", 64'(uop_count), 64'd0);
        chk("rst_pc", 64'(pc_out), 64'd0);
        chk("rst_f_ready", 64'(f_ready), 64'd1);
        rst = 1'b0;
        step();

        // Decode table: one instruction into an idle block, then drain it.
        for (int i = 0; i < vecs.size(); i++) begin
            f_valid = 1'b1; f_instr = vecs[i].instr; f_exception = vecs[i].fexc;
            f_pc = 32'h1000 + 32'(4 * i);
            step();
            chk("tbl_latency", 64'(valid_out), 64'd0);
            f_valid = 1'b0; f_exception = 1'b0;
            step();
            chk("tbl_valid", 64'(valid_out), 64'd1);
            chk("tbl_pc", 64'(pc_out), 64'(32'h1000 + 32'(4 * i)));
            chk("tbl_fmt", 64'(opcode_format), 64'(vecs[i].fmt));
            chk("tbl_cnt", 64'(uop_count), 64'(vecs[i].cnt));
            chk("tbl_exc", 64'(exception_out), 64'(vecs[i].exc));
            chk("tbl_idx0", 64'(uop_idx), 64'd0);
            for (int k = 1; k <= int'(vecs[i].cnt); k++) begin
                step();
                chk("tbl_idx_k", {uop_idx, 1'b0, valid_out}, {2'(k), 1'b0, 1'b1});
            end
            step();
            chk("tbl_done", 64'(valid_out), 64'd0);
        end

        // Store then ADD back-to-back
        f_valid = 1'b1; f_instr = SW; f_pc = 32'h2000;
        step();
        f_instr = ADD; f_pc = 32'h2004;
        chk("b2b_ready", 64'(f_ready), 64'd1);
        step();
        f_valid = 1'b0;
        chk("b2b_sw0", {instruction_out, 6'd0, uop_count, uop_idx, valid_out}, {SW, 6'd0, 2'd1, 2'd0, 1'b1});
        step();
        chk("b2b_sw1", {instruction_out, 6'd0, uop_count, uop_idx, valid_out}, {SW, 6'd0, 2'd1, 2'd1, 1'b1});
        step();
        chk("b2b_add", {instruction_out, 6'd0, uop_count, uop_idx, valid_out}, {ADD, 6'd0, 2'd0, 2'd0, 1'b1});
        chk("b2b_add_pc", 64'(pc_out), 64'h2004);
        step();
        chk("b2b_idle", 64'(valid_out), 64'd0);

        // Stall and backpressure
        stall_in = 1'b1;
        f_valid = 1'b1; f_instr = ADD; f_pc = 32'h3000;
        step();
        f_instr = ADDI; f_pc = 32'h3004;
        step();
        f_instr = LUI; f_pc = 32'h3008;
        step();
        chk("bp_ready_low", 64'(f_ready), 64'd0);
        chk("bp_hold_pc", 64'(pc_out), 64'h3000);
        f_instr = SW; f_pc = 32'h300C;
        step();
        chk("bp_hold_pc2", {pc_out, 31'd0, valid_out}, {32'h3000, 31'd0, 1'b1});
        chk("bp_ready_low2", 64'(f_ready), 64'd0);
        f_valid = 1'b0; stall_in = 1'b0;
        step();
        chk("bp_second", {pc_out, instruction_out}, {32'h3004, ADDI});
        step();
        chk("bp_third", {pc_out, instruction_out}, {32'h3008, LUI});
        step();
        chk("bp_idle", 64'(valid_out), 64'd0);

        // Flush during second uop of JAL with one entry buffered
        f_valid = 1'b1; f_instr = JAL; f_pc = 32'h4000;
        step();
        f_instr = ADD; f_pc = 32'h4004;
        step();
        f_valid = 1'b0;
        step();
        chk("fl_jal_idx1", {instruction_out, 29'd0, uop_idx, valid_out}, {JAL, 29'd0, 2'd1, 1'b1});
        flush = 1'b1; f_valid = 1'b1; f_instr = ADDI; f_pc = 32'h4100;
        step();
        flush = 1'b0; f_valid = 1'b0;
        chk("fl_valid", 64'(valid_out), 64'd0);
        chk("fl_idx", 64'(uop_idx), 64'd0);
        chk("fl_ready", 64'(f_ready), 64'd1);
        step(); step();
        chk("fl_empty", 64'(valid_out), 64'd0);

        // Reset mid-instruction
        f_valid = 1'b1; f_instr = SW; f_pc = 32'h5000;
        step();
        f_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid", {pc_out, 29'd0, uop_idx, valid_out}, 64'd0);
        step();
        chk("rst_mid_idle", 64'(valid_out), 64'd0);

        // Random traffic checked against the expected uop stream
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] rf;
            logic [1:0] rn;
            logic       re;
            uop_t       u;
            flush       = ($urandom_range(0, 99) < 2);
            stall_in    = ($urandom_range(0, 99) < 30);
            f_valid     = ($urandom_range(0, 99) < 60);
            f_exception = ($urandom_range(0, 9) == 0);
            f_pc        = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) f_instr = $urandom;
            else f_instr = vecs[$urandom_range(0, vecs.size() - 1)].instr;
            if (flush) begin
                q.delete();
            end else begin
                consume_check();
                if (f_valid && f_ready) begin
                    ref_dec(f_instr, f_exception, rf, rn, re);
                    for (int k = 0; k <= int'(rn); k++) begin
                        u.pc = f_pc; u.instr = f_instr; u.fmt = rf; u.cnt = rn;
                        u.idx = 2'(k); u.exc = re;
                        q.push_back(u);
                    end
                end
            end
            step();
        end

        // Drain with a bounded cycle budget
        flush = 1'b0; f_valid = 1'b0; f_exception = 1'b0; stall_in = 1'b0;
        for (int c = 0; c < 40; c++) begin
            consume_check();
            step();
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
        chk("drain_idle", 64'(valid_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
